gray_step_counter: RTL and testbench

Consumes the one-cycle tick stream from the periodic pulse generator and advances a WIDTH-bit counter by one step per tick. The counter is published as registered Gray code, so exactly one output bit changes per step, and as registered binary. Supports direction control, synchronous load of a Gray value, and optional saturation. Sits directly downstream of the tick source and drives LEDs or a cross-domain consumer.

---
 rtl/gray_step_counter_pkg.sv | 27 ++
 rtl/gray_step_counter_gray_to_bin_conv.sv | 17 +
 rtl/gray_step_counter.sv | 92 +++++++++
 tb/tb_gray_step_counter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/gray_step_counter_pkg.sv
// Shared definitions for the Gray-code step counter.
//   DIR_UP / DIR_DOWN : encoding of the dir input
//   MAX_WIDTH         : widest counter the helpers support
//   bin_to_gray       : x ^ (x >> 1)
//   gray_to_bin       : prefix XOR from the MSB down
// The helpers work on MAX_WIDTH bits; narrower callers zero-extend,
// which leaves the result unchanged in the low bits.
package gray_step_counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam int   MAX_WIDTH = 16;

    function automatic logic [MAX_WIDTH-1:0] bin_to_gray(input logic [MAX_WIDTH-1:0] x);
        return x ^ (x >> 1);
    endfunction

    // Bit i of the binary value is the XOR of all Gray bits at or above i.
    function automatic logic [MAX_WIDTH-1:0] gray_to_bin(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_step_counter_gray_to_bin_conv.sv
// Combinational WIDTH-bit Gray-to-binary converter.
//   gray : Gray-coded input
//   bin  : binary equivalent
module gray_to_bin_conv #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each output bit reduces the Gray slice from the MSB down to itself,
    // so no output bit depends on another output bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_step_counter.sv
// Tick-driven up/down counter published in registered Gray and binary form.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   tick      : one-cycle step request
//   enable    : 1 = honour tick
//   dir       : 1 = up, 0 = down (sampled with tick)
//   load      : synchronous load strobe, overrides tick
//   load_gray : Gray value to load
//   gray      : registered Gray count
//   bin       : registered binary count
//   terminal  : one-cycle pulse on wrap or on a step refused at a limit
module gray_step_counter
    import gray_step_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             enable,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             terminal
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic             SAT      = (SATURATE != 0);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             term_q;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_next;
    logic             term_next;
    logic [WIDTH-1:0] load_bin;

    gray_to_bin_conv #(.WIDTH(WIDTH)) u_load_conv (
        .gray (load_gray),
        .bin  (load_bin)
    );

    always_comb begin
        bin_next  = bin_q;
        term_next = 1'b0;
        if (load) begin
            bin_next = load_bin;
        end else if (tick && enable) begin
            if (dir == DIR_UP) begin
                if (bin_q == ALL_ONES) begin
                    term_next = 1'b1;
                    bin_next  = SAT ? bin_q : ZERO;
                end else begin
                    bin_next = bin_q + ONE;
                end
            end else begin
                if (bin_q == ZERO) begin
                    term_next = 1'b1;
                    bin_next  = SAT ? bin_q : ALL_ONES;
                end else begin
                    bin_next = bin_q - ONE;
                end
            end
        end
    end

    // Gray is derived from the next binary value so both registers update
    // on the same edge and gray never glitches through a combinational path.
    assign gray_next = bin_next ^ (bin_next >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
            term_q <= 1'b0;
        end else begin
            bin_q  <= bin_next;
            gray_q <= gray_next;
            term_q <= term_next;
        end
    end

    assign bin      = bin_q;
    assign gray     = gray_q;
    assign terminal = term_q;

endmodule

// File: tb/tb_gray_step_counter.sv
module tb_gray_step_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         tb_tick = 1'b0;
    logic         enable = 1'b1;
    logic         dir = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] load_gray = '0;
    logic         tick;
    logic [W-1:0] gray, bin, ref_bin;
    logic         terminal;

    logic         s_tick = 1'b0;
    logic         s_dir = 1'b1;
    logic         s_load = 1'b0;
    logic [W-1:0] s_load_gray = '0;
    logic [W-1:0] s_gray, s_bin;
    logic         s_terminal;

    // Upstream periodic pulse generator model, RESET_AT = 3.
    logic         use_pg = 1'b0;
    logic [1:0]   pg_cnt;
    logic         pg_tick;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pg_cnt <= 2'd0;
        else        pg_cnt <= (pg_cnt == 2'd3) ? 2'd0 : pg_cnt + 2'd1;
    end
    assign pg_tick = (pg_cnt == 2'd3);
    assign tick    = use_pg ? pg_tick : tb_tick;

    gray_step_counter #(.WIDTH(W), .SATURATE(0)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .enable(enable), .dir(dir),
        .load(load), .load_gray(load_gray), .gray(gray), .bin(bin), .terminal(terminal)
    );

    gray_step_counter #(.WIDTH(W), .SATURATE(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .tick(s_tick), .enable(1'b1), .dir(s_dir),
        .load(s_load), .load_gray(s_load_gray), .gray(s_gray), .bin(s_bin), .terminal(s_terminal)
    );

    gray_to_bin_conv #(.WIDTH(W)) u_ref (.gray(gray), .bin(ref_bin));

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_main(input string tag, input logic [3:0] eb, input logic [3:0] eg, input logic et);
        check({tag, ".bin"}, 16'(bin), 16'(eb));
        check({tag, ".gray"}, 16'(gray), 16'(eg));
        check({tag, ".term"}, 16'(terminal), 16'(et));
    endtask

    task automatic expect_sat(input string tag, input logic [3:0] eb, input logic [3:0] eg, input logic et);
        check({tag, ".bin"}, 16'(s_bin), 16'(eb));
        check({tag, ".gray"}, 16'(s_gray), 16'(eg));
        check({tag, ".term"}, 16'(s_terminal), 16'(et));
    endtask

    logic [3:0] gseq [0:15] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    initial begin
        logic [3:0] prev_g;
        logic [3:0] base;
        bit         found;

        // Reset with no clock edge involved
        #2 rst_n = 1'b0;
        #1 expect_main("reset0", 4'h0, 4'h0, 1'b0);
        expect_sat("reset0_sat", 4'h0, 4'h0, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        step();
        expect_main("post_release", 4'h0, 4'h0, 1'b0);

        // Up count through a full wrap
        tb_tick = 1'b1; dir = 1'b1;
        prev_g = gray;
        for (int i = 1; i <= 16; i++) begin
            step();
            check($sformatf("up%0d.gray", i), 16'(gray), 16'(gseq[i % 16]));
            check($sformatf("up%0d.onebit", i), 16'($countones(gray ^ prev_g)), 16'd1);
            check($sformatf("up%0d.term", i), 16'(terminal), (i == 16) ? 16'd1 : 16'd0);
            check($sformatf("up%0d.bin_vs_ref", i), 16'(bin), 16'(ref_bin));
            prev_g = gray;
        end
        tb_tick = 1'b0;
        step();
        expect_main("idle_after_wrap", 4'h0, 4'h0, 1'b0);

        // Down from zero wraps to all-ones
        tb_tick = 1'b1; dir = 1'b0;
        step();
        expect_main("down_wrap", 4'hF, 4'h8, 1'b1);
        step();
        expect_main("down_14", 4'hE, 4'h9, 1'b0);
        tb_tick = 1'b0;

        // Load bin=5 then reset asynchronously with a step pending
        load = 1'b1; load_gray = 4'h7;
        step();
        expect_main("load5", 4'h5, 4'h7, 1'b0);
        load = 1'b0; tb_tick = 1'b1; dir = 1'b1;
        rst_n = 1'b0;
        #1 expect_main("async_reset", 4'h0, 4'h0, 1'b0);
        step();
        tb_tick = 1'b0;
        rst_n = 1'b1;
        step();
        expect_main("hold_after_reset1", 4'h0, 4'h0, 1'b0);
        step();
        expect_main("hold_after_reset2", 4'h0, 4'h0, 1'b0);

        // Load beats tick in the same cycle
        load = 1'b1; load_gray = 4'hC; tb_tick = 1'b1; dir = 1'b1;
        step();
        expect_main("load_vs_tick", 4'h8, 4'hC, 1'b0);
        load = 1'b0;

        // Disabled ticks are ignored
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_main($sformatf("disabled%0d", i), 4'h8, 4'hC, 1'b0);
        end
        tb_tick = 1'b0; enable = 1'b1;

        // Saturating instance
        s_load = 1'b1; s_load_gray = 4'h8;
        step();
        expect_sat("sat_load15", 4'hF, 4'h8, 1'b0);
        s_load = 1'b0; s_tick = 1'b1; s_dir = 1'b1;
        step();
        expect_sat("sat_hold_top", 4'hF, 4'h8, 1'b1);
        s_dir = 1'b0;
        step();
        expect_sat("sat_down14", 4'hE, 4'h9, 1'b0);
        s_tick = 1'b0; s_load = 1'b1; s_load_gray = 4'h0;
        step();
        s_load = 1'b0; s_tick = 1'b1; s_dir = 1'b0;
        step();
        expect_sat("sat_hold_bottom", 4'h0, 4'h0, 1'b1);
        s_tick = 1'b0;
        step();
        expect_sat("sat_idle", 4'h0, 4'h0, 1'b0);

        // Integration with the pulse generator: one step every 4 clocks
        dir = 1'b1;
        base = bin;
        use_pg = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step();
            if (bin != base) found = 1'b1;
        end
        check("pg_first_tick_seen", 16'(found), 16'd1);
        base = bin;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 3; k++) begin
                step();
                check($sformatf("pg_p%0d_idle%0d", p, k), 16'(bin), 16'(base));
            end
            step();
            base = base + 4'd1;
            check($sformatf("pg_p%0d_step", p), 16'(bin), 16'(base));
        end
        use_pg = 1'b0;

        // Back-to-back ticks step every cycle
        tb_tick = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            base = base + 4'd1;
            check($sformatf("b2b%0d", i), 16'(bin), 16'(base));
        end
        tb_tick = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
